// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// Holds the FSM state encoding and the default widths used by the loader, its RAM and its interface.
package imem_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int HOLD_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream load channel between a host (master) and the loader (slave).
// It carries the session request and the valid/ready byte handshake.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              load_start;
    logic [ADDR_W-1:0] load_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output load_start,
        output load_len,
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  load_start,
        input  load_len,
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/imem_ram.sv
// Instruction store: one synchronous write port and one asynchronous read port.
// The contents start at zero and are never cleared by reset.
module imem_ram
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The processor fetches directly from the array, so a write shows up right after its edge.
    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory while holding the processor in reset,
// then releases it a fixed number of cycles after the last byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    imem_loader_if.slave      ld,
    input  logic [ADDR_W-1:0] Read_Address,
    output logic [DATA_W-1:0] instruction,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic [DATA_W-1:0] checksum
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(1 << ADDR_W);
    localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(HOLD_CYCLES);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [DATA_W-1:0] checksum_reg, checksum_next;
    logic              cpu_hold_reg, cpu_hold_next;
    logic              load_done_reg, load_done_next;
    logic              xfer;
    logic              mem_we;

    assign ld.in_ready = (state_reg == ST_LOAD);
    assign xfer        = (state_reg == ST_LOAD) && ld.in_valid;
    // Reset wins over a transfer presented on the same edge.
    assign mem_we      = xfer && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wr_addr_reg   <= '0;
            remaining_reg <= '0;
            hold_cnt_reg  <= '0;
            checksum_reg  <= '0;
            cpu_hold_reg  <= 1'b0;
            load_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_addr_reg   <= wr_addr_next;
            remaining_reg <= remaining_next;
            hold_cnt_reg  <= hold_cnt_next;
            checksum_reg  <= checksum_next;
            cpu_hold_reg  <= cpu_hold_next;
            load_done_reg <= load_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wr_addr_next   = wr_addr_reg;
        remaining_next = remaining_reg;
        hold_cnt_next  = hold_cnt_reg;
        checksum_next  = checksum_reg;
        cpu_hold_next  = cpu_hold_reg;
        load_done_next = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (ld.load_start) begin
                    state_next     = ST_LOAD;
                    wr_addr_next   = '0;
                    // A zero length encodes a full-depth session.
                    remaining_next = (ld.load_len == '0) ? FULL_COUNT : CNT_W'(ld.load_len);
                    checksum_next  = '0;
                    cpu_hold_next  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    wr_addr_next   = wr_addr_reg + 1'b1;
                    checksum_next  = checksum_reg + ld.in_data;
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next    = ST_HOLD;
                        hold_cnt_next = HOLD_INIT;
                    end
                end
            end
            ST_HOLD: begin
                hold_cnt_next = hold_cnt_reg - 1'b1;
                if (hold_cnt_reg <= HOLD_W'(1)) begin
                    hold_cnt_next  = '0;
                    state_next     = ST_IDLE;
                    cpu_hold_next  = 1'b0;
                    load_done_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    imem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr_reg),
        .wdata (ld.in_data),
        .raddr (Read_Address),
        .rdata (instruction)
    );

    assign cpu_hold  = cpu_hold_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign load_done = load_done_reg;
    assign checksum  = checksum_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader, checked against a byte-array model
// of memory contents, running checksum and session timing.
module tb_imem_loader;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int HC    = 2;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] raddr;
    logic [DW-1:0] instruction;
    logic          cpu_hold;
    logic          busy;
    logic          load_done;
    logic [DW-1:0] checksum;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) ld ();

    imem_loader #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ld           (ld),
        .Read_Address (raddr),
        .instruction  (instruction),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .load_done    (load_done),
        .checksum     (checksum)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] model_mem [DEPTH];
    int         model_sum;
    int         model_wr;
    bit         vpat [$];
    bit         vrand;
    logic [7:0] dq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input string tag);
        ld.in_valid = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            raddr = 8'(a);
            #1;
            check($sformatf("%s mem[%0h]", tag, a), 32'(instruction), 32'(model_mem[a]));
        end
        $display("[TB] memory sweep %s done", tag);
    endtask

    task automatic start(input int len);
        ld.load_start = 1'b1;
        ld.load_len   = 8'(len % DEPTH);
        tick();
        ld.load_start = 1'b0;
        model_sum = 0;
        model_wr  = 0;
        check("start busy", 32'(busy), 32'd1);
        check("start cpu_hold", 32'(cpu_hold), 32'd1);
        check("start in_ready", 32'(ld.in_ready), 32'd1);
        check("start checksum", 32'(checksum), 32'd0);
        check("start load_done", 32'(load_done), 32'd0);
    endtask

    task automatic session(input int len, input int watch, input int restart_at);
        int         n   = 0;
        int         cyc = 0;
        bit         v;
        logic [7:0] d;
        raddr = 8'(watch);
        while (n < len && cyc < 4000) begin
            v = (vpat.size() != 0) ? vpat.pop_front() : (vrand ? 1'($urandom_range(0, 1)) : 1'b1);
            if (v) d = (dq.size() != 0) ? dq.pop_front() : 8'($urandom);
            else   d = 8'($urandom);
            ld.in_valid = v;
            ld.in_data  = d;
            if (cyc == restart_at) begin
                ld.load_start = 1'b1;
                ld.load_len   = 8'd9;
            end
            check("in_ready during load", 32'(ld.in_ready), 32'd1);
            check("read before edge", 32'(instruction), 32'(model_mem[watch]));
            tick();
            ld.load_start = 1'b0;
            if (v) begin
                model_mem[model_wr] = d;
                model_sum = (model_sum + int'(d)) % 256;
                model_wr  = (model_wr + 1) % DEPTH;
                n++;
                $display("[TB] write #%0d data=%02h sum=%02h", n, d, model_sum);
            end
            check("read after edge", 32'(instruction), 32'(model_mem[watch]));
            check("running checksum", 32'(checksum), 32'(model_sum));
            cyc++;
        end
        check("session byte count", 32'(n), 32'(len));
        check("in_ready after last byte", 32'(ld.in_ready), 32'd0);
        for (int k = 1; k <= HC; k++) begin
            ld.in_valid = 1'b1;
            ld.in_data  = 8'($urandom);
            tick();
            check($sformatf("load_done hold+%0d", k), 32'(load_done), 32'(k == HC));
            check($sformatf("cpu_hold hold+%0d", k), 32'(cpu_hold), 32'(k < HC));
            check($sformatf("busy hold+%0d", k), 32'(busy), 32'(k < HC));
            check("hold ignores in_valid", 32'(instruction), 32'(model_mem[watch]));
        end
        ld.in_valid = 1'b0;
        tick();
        check("load_done one cycle", 32'(load_done), 32'd0);
        check("final checksum", 32'(checksum), 32'(model_sum));
        check("final wr_addr", 32'(dut.wr_addr_reg), 32'(model_wr));
        $display("[TB] session len=%0d done checksum=%02h", len, model_sum);
    endtask

    initial begin
        logic [7:0] c;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;
        rst = 1'b1;
        raddr = '0;
        ld.load_start = 1'b0;
        ld.load_len = '0;
        ld.in_valid = 1'b0;
        ld.in_data = '0;
        vrand = 1'b0;
        tick(); tick(); tick();
        check("reset in_ready", 32'(ld.in_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset cpu_hold", 32'(cpu_hold), 32'd0);
        check("reset load_done", 32'(load_done), 32'd0);
        check("reset checksum", 32'(checksum), 32'd0);
        rst = 1'b0;
        tick();
        sweep("init zeros");

        // Three-byte session with valid held high.
        dq = '{8'h11, 8'h22, 8'h33};
        start(3);
        session(3, 1, -1);
        check("three-byte checksum", 32'(checksum), 32'h66);
        sweep("len3");

        // Gapped valid pattern.
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        start(3);
        session(3, 2, -1);
        sweep("gapped");

        // Restart request in mid-session must be ignored.
        vrand = 1'b1;
        start(5);
        session(5, 0, 2);
        vrand = 1'b0;
        sweep("restart ignored");

        // Watch address 5 while 0xA5 lands there.
        dq = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'hA5};
        start(6);
        session(6, 5, -1);
        check("watched byte", 32'(instruction), 32'hA5);

        // Bytes presented in IDLE are dropped; reset beats load_start.
        for (int i = 0; i < 4; i++) begin
            ld.in_valid = 1'b1;
            ld.in_data  = 8'($urandom);
            tick();
            check("idle stays idle", 32'(busy), 32'd0);
        end
        ld.in_valid = 1'b0;
        rst = 1'b1;
        ld.load_start = 1'b1;
        ld.load_len = 8'd4;
        tick();
        rst = 1'b0;
        ld.load_start = 1'b0;
        check("rst beats load_start", 32'(busy), 32'd0);
        sweep("idle ignore");

        // Reset after two of four bytes aborts the session.
        start(4);
        for (int i = 0; i < 2; i++) begin
            ld.in_valid = 1'b1;
            ld.in_data  = 8'($urandom);
            tick();
            model_mem[model_wr] = ld.in_data;
            model_wr++;
        end
        c = ~model_mem[2];
        ld.in_data = c;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ld.in_valid = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort cpu_hold", 32'(cpu_hold), 32'd0);
        check("abort in_ready", 32'(ld.in_ready), 32'd0);
        check("abort checksum", 32'(checksum), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("abort no load_done", 32'(load_done), 32'd0);
            tick();
        end
        sweep("abort");

        // Full-depth session encoded by length 0.
        for (int i = 0; i < DEPTH; i++) dq.push_back(8'(i));
        start(0);
        session(DEPTH, 255, -1);
        check("full checksum", 32'(checksum), 32'h80);
        check("full wr_addr wrapped", 32'(dut.wr_addr_reg), 32'd0);
        sweep("full");

        // Random sessions with random gaps.
        vrand = 1'b1;
        for (int s = 0; s < 3; s++) begin
            int len = int'($urandom_range(1, 40));
            start(len);
            session(len, int'($urandom_range(0, 63)), -1);
            sweep($sformatf("random %0d", s));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, 8, instruction address width; memory depth is 2**ADDR_W.
REQ-002 Parameter: DATA_W, 8, instruction word width.
REQ-003 Parameter: HOLD_CYCLES, 2, cycles cpu_hold stays high after the last byte is written (legal range 1..15).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 Read_Address  input  ADDR_W  processor PC; read port address.
REQ-007 instruction  output  DATA_W  mem[Read_Address]; combinational read.
REQ-008 load_start  input  1  single-cycle request to begin a load session.
REQ-009 load_len  input  ADDR_W  byte count for the session, sampled with load_start; 0 encodes 2**ADDR_W.
REQ-010 in_valid  input  1  in_data is valid.
REQ-011 in_data  input  DATA_W  byte to be written.
REQ-012 in_ready  output  1  loader accepts in_data this cycle.
REQ-013 cpu_hold  output  1  drives processor reset while a session is active.
REQ-014 busy  output  1  session in progress (state != IDLE).
REQ-015 load_done  output  1  one-cycle pulse when a session completes.
REQ-016 checksum  output  DATA_W  sum mod 2**DATA_W of all bytes written in the current or last session.

Function
REQ-017 States SHALL be IDLE, LOAD, and HOLD.
REQ-018 IDLE -> LOAD when load_start=1: wr_addr<=0, remaining<=load_len (0 means 256), checksum<=0, cpu_hold<=1.
REQ-019 in_ready SHALL be 1 exactly while in LOAD; in_ready SHALL NOT depend combinationally on in_valid.
REQ-020 Transfer SHALL occur on an edge where in_valid=1 and in_ready=1: mem[wr_addr]<=in_data, wr_addr<=wr_addr+1 (mod 2**ADDR_W), checksum<=checksum+in_data (mod 2**DATA_W), remaining decremented.
REQ-021 A transfer of the last byte (remaining=1) SHALL move LOAD -> HOLD and load a hold counter with HOLD_CYCLES.
REQ-022 HOLD SHALL decrement the counter each cycle; when it reaches 0 the state SHALL return to IDLE, with cpu_hold=0 and load_done=1 for that single cycle.
REQ-023 cpu_hold SHALL be 1 from the cycle after load_start is accepted until the load_done cycle, exclusive.
REQ-024 load_start SHALL be ignored while busy=1.
REQ-025 in_valid SHALL be ignored in IDLE and HOLD; memory is not written in those states.
REQ-026 A 256-byte session SHALL end with wr_addr wrapped to 0; no byte is written twice.
REQ-027 A read whose Read_Address equals the address written at edge N SHALL return the old byte before edge N and the new byte after it.
REQ-028 Memory contents SHALL be unchanged outside transfers.

Reset
REQ-029 While rst=1 at an edge: state<=IDLE, wr_addr<=0, remaining<=0, hold counter<=0, checksum<=0, cpu_hold<=0, load_done<=0; in_ready=0, busy=0.
REQ-030 rst SHALL take priority over load_start and any transfer in the same cycle.
REQ-031 Reset during a session SHALL abort the session with no load_done pulse.
REQ-032 Memory contents SHALL NOT be cleared by rst; bytes already written are retained.
REQ-033 Memory SHALL initialise to all zeros at configuration.

Structure
REQ-034 A shared package SHALL hold the state enumeration (IDLE/LOAD/HOLD), ADDR_W/DATA_W defaults, and the HOLD counter width (4).
REQ-035 Storage SHALL be a sub-module imem_ram: 2**ADDR_W x DATA_W, one synchronous write port, one asynchronous read port.
REQ-036 imem_loader SHALL contain the FSM, counters, and checksum, and SHALL instantiate imem_ram once.

Verification
REQ-037 load_start with load_len=3, then bytes 0x11, 0x22, 0x33 with in_valid held high -> mem[0..2]=11,22,33; checksum=0x66; load_done pulses exactly 2 cycles after the third transfer; cpu_hold then 0.
REQ-038 load_len=0, with 256 bytes of value i at address i -> instruction at Read_Address=0xFF is 0xFF; checksum=0x80; wr_addr=0.
REQ-039 in_valid toggling 1,0,0,1,1 during a load_len=3 session -> exactly 3 writes, to consecutive addresses, and in_ready stays 1 throughout LOAD.
REQ-040 rst asserted after 2 of 4 bytes -> state IDLE, cpu_hold=0, no load_done; mem[0..1] hold new data, mem[2..3] hold old data.
REQ-041 load_start pulsed during LOAD with load_len=9 -> ignored; session ends after the original count.
REQ-042 Read_Address=5 held while byte 0xA5 is written to address 5 -> instruction changes from the old value to 0xA5 exactly after that edge.
